mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_pkg.sv | 42 ++++
 rtl/dmem_bytelane.sv | 31 +++
 rtl/mem_access_unit.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// Shared definitions for mem_access_unit: access-size encodings, FSM state
// type, and helpers for byte-enable and alignment. The lane helpers assume
// an 8-byte datapath (DATA_W = 64).
package mem_access_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE  = 2'b00,
    SIZE_HALF  = 2'b01,
    SIZE_WORD  = 2'b10,
    SIZE_DWORD = 2'b11
  } mem_size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mau_state_e;

  // True when the byte offset is a multiple of the access size.
  function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] off);
    logic ok;
    case (mem_size_e'(size))
      SIZE_BYTE: ok = 1'b1;
      SIZE_HALF: ok = (off[0] == 1'b0);
      SIZE_WORD: ok = (off[1:0] == 2'b00);
      default:   ok = (off == 3'b000);
    endcase
    return ok;
  endfunction

  // Lanes touched by an access of the given size starting at the given offset.
  function automatic logic [7:0] byte_enable(input logic [1:0] size, input logic [2:0] off);
    logic [7:0] base;
    case (mem_size_e'(size))
      SIZE_BYTE: base = 8'h01;
      SIZE_HALF: base = 8'h03;
      SIZE_WORD: base = 8'h0F;
      default:   base = 8'hFF;
    endcase
    return base << off;
  endfunction

endpackage

// File: rtl/dmem_bytelane.sv
// Byte-enabled data memory, MEM_DEPTH words of DATA_W bits. Writes are
// synchronous per byte lane; the read port is asynchronous so the owner can
// register the selected data on the same edge that commits the access.
// Contents are not reset.
module dmem_bytelane #(
  parameter int DATA_W    = 64,
  parameter int MEM_DEPTH = 256,
  parameter int AW        = 8
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  // Update only the enabled byte lanes of the addressed word.
  always_ff @(posedge clock) begin
    if (we) begin
      for (int i = 0; i < DATA_W / 8; i++) begin
        if (be[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_access_unit.sv
// Memory-access pipeline stage: resolves the branch PC-source select, and
// performs byte/half/word/dword loads and stores against a private
// little-endian, byte-addressed memory with WAIT_CYCLES of extra latency.
// Optional feature: define MEM_ACCESS_STATS_EN to build saturating
// load/store/stall statistics counters; otherwise those ports read 0.
//
// Handshake: stall is combinational. While stall is high the upstream stage
// holds every input steady; the op commits on the edge that ends the first
// cycle in which stall is low, and valid_out pulses for one cycle after it.
// MEM_DEPTH must be a power of two (word index wraps by truncation).
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int DATA_W      = 64,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] write_data,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [1:0]        mem_size,
  input  logic              sign_ext,
  input  logic              zero,
  input  logic              not_zero,
  input  logic              Branch,
  input  logic              Uncondbranch,
  output logic              stall,
  output logic              or_out,
  output logic              valid_out,
  output logic [DATA_W-1:0] read_data,
  output logic [DATA_W-1:0] alu_result_out,
  output logic              misalign_fault,
  output logic [31:0]       load_count,
  output logic [31:0]       store_count,
  output logic [31:0]       stall_count
);

  localparam int         AW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam bit         WAIT_EN   = (WAIT_CYCLES != 0);
  localparam logic [2:0] WAIT_LOAD = 3'(WAIT_CYCLES - 1);

  mau_state_e        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic              fault_q, fault_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] alu_q, alu_d;

  logic [2:0]        off;
  logic [AW-1:0]     word_idx;
  logic              is_mem, aligned, commit, do_store, do_load;
  logic [7:0]        be;
  logic [DATA_W-1:0] mem_rdata, wdata_sh, rd_sh, load_val;

  assign or_out   = valid_in & (Uncondbranch | (Branch & (not_zero ? ~zero : zero)));
  assign off      = alu_result[2:0];
  assign word_idx = alu_result[3 +: AW];
  assign is_mem   = MemRead | MemWrite;
  assign aligned  = is_aligned(mem_size, off);
  assign be       = byte_enable(mem_size, off);
  assign wdata_sh = write_data << {off, 3'b000};
  assign rd_sh    = mem_rdata >> {off, 3'b000};
  assign do_store = commit & is_mem & aligned & MemWrite;
  assign do_load  = commit & aligned & MemRead & ~MemWrite;

  dmem_bytelane #(
    .DATA_W    (DATA_W),
    .MEM_DEPTH (MEM_DEPTH),
    .AW        (AW)
  ) u_dmem (
    .clock (clock),
    .we    (do_store & ~reset),
    .be    (be),
    .addr  (word_idx),
    .wdata (wdata_sh),
    .rdata (mem_rdata)
  );

  // Sequencing: IDLE accepts ops; aligned memory ops wait out the latency in WAIT.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (valid_in) begin
          if (is_mem && aligned && WAIT_EN) begin
            stall   = 1'b1;
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            commit = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        // valid_in is deliberately ignored here: the op already started.
        if (cnt_q != 3'd0) begin
          stall = 1'b1;
          cnt_d = cnt_q - 3'd1;
        end else begin
          commit  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Right-align the selected bytes and extend to the full width.
  always_comb begin
    load_val = rd_sh;
    case (mem_size_e'(mem_size))
      SIZE_BYTE: load_val = {{(DATA_W-8){sign_ext & rd_sh[7]}}, rd_sh[7:0]};
      SIZE_HALF: load_val = {{(DATA_W-16){sign_ext & rd_sh[15]}}, rd_sh[15:0]};
      SIZE_WORD: load_val = {{(DATA_W-32){sign_ext & rd_sh[31]}}, rd_sh[31:0]};
      default:   load_val = rd_sh;
    endcase
  end

  // Result registers: load on commit, valid/fault are single-cycle pulses.
  always_comb begin
    valid_d = commit;
    fault_d = commit & is_mem & ~aligned;
    rdata_d = rdata_q;
    alu_d   = alu_q;
    if (commit) begin
      alu_d   = alu_result;
      rdata_d = do_load ? load_val : '0;
    end
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      rdata_q <= '0;
      alu_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      rdata_q <= rdata_d;
      alu_q   <= alu_d;
    end
  end

  assign valid_out      = valid_q;
  assign misalign_fault = fault_q;
  assign read_data      = rdata_q;
  assign alu_result_out = alu_q;

`ifdef MEM_ACCESS_STATS_EN
  logic [31:0] load_cnt_q, load_cnt_d;
  logic [31:0] store_cnt_q, store_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating statistics: completed loads, completed stores, stall cycles.
  always_comb begin
    load_cnt_d  = load_cnt_q;
    store_cnt_d = store_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (do_load  && load_cnt_q  != 32'hFFFF_FFFF) load_cnt_d  = load_cnt_q  + 32'd1;
    if (do_store && store_cnt_q != 32'hFFFF_FFFF) store_cnt_d = store_cnt_q + 32'd1;
    if (stall    && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // Statistics registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      load_cnt_q  <= 32'd0;
      store_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      load_cnt_q  <= load_cnt_d;
      store_cnt_q <= store_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign load_count  = load_cnt_q;
  assign store_count = store_cnt_q;
  assign stall_count = stall_cnt_q;
`else
  assign load_count  = 32'd0;
  assign store_count = 32'd0;
  assign stall_count = 32'd0;
`endif

endmodule
